// File: rtl/perf_counter_bank.sv
// Event counter bank: NUM_CH saturating/wrapping counters, run/freeze control, registered read port.
// Optional cycle counter at rd_sel == NUM_CH when PERF_CYCLE_CNT_EN is defined.
module perf_counter_bank #(
  parameter int NUM_CH   = 6,
  parameter int CNT_W    = 32,
  parameter int SEL_W    = 3,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              clr,
  input  logic              stall,
  input  logic [NUM_CH-1:0] evt,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              frozen,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ONES = '1;

  state_e state_q, state_d;
  logic frozen_q, frozen_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] inc;
  logic rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic run;

  function automatic logic [CNT_W-1:0] bump(
    input logic [CNT_W-1:0] v
  );
    if (v == ONES) begin
      if (SATURATE != 0) return ONES;
      return '0;
    end
    return v + CNT_W'(1);
  endfunction

`ifdef PERF_CYCLE_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
`endif

  assign run = (state_q == RUN);
  assign inc = evt & ~{NUM_CH{stall}} & {NUM_CH{run}};

  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      clr:                       state_d = IDLE;
      run && halt:               state_d = FROZEN;
      (state_q == IDLE) && start: state_d = RUN;
      default: ;
    endcase
    frozen_d = (state_d == FROZEN);
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (inc[i]) begin
        cnt_d[i] = bump(cnt_q[i]);
        if (cnt_q[i] == ONES) ovf_d[i] = 1'b1;
      end
    end
  end

`ifdef PERF_CYCLE_CNT_EN
  always_comb begin
    cyc_d = cyc_q;
    if (clr) cyc_d = '0;
    else if (run) cyc_d = bump(cyc_q);
  end
`endif

  // Reads see pre-update counter state, so a same-cycle clr or event is not visible.
  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    if (rd_req) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_sel == SEL_W'(i)) rd_data_d = cnt_q[i];
      end
`ifdef PERF_CYCLE_CNT_EN
      if (rd_sel == SEL_W'(NUM_CH)) rd_data_d = cyc_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frozen_q   <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      frozen_q   <= frozen_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef PERF_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end
`endif

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign ovf      = ovf_q;
  assign frozen   = frozen_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: saturating and wrapping instances share stimulus;
// expectations come from unbounded event tallies folded into CNT_W=4.
module tb_perf_counter_bank;

  localparam int NCH  = 6;
  localparam int W    = 4;
  localparam int SW   = 3;
  localparam int MAXV = 15;
`ifdef PERF_CYCLE_CNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 0, halt = 0, clr = 0, stall = 0, rd_req = 0;
  logic [NCH-1:0] evt = '0;
  logic [SW-1:0] rd_sel = '0;

  logic rv_s, rv_w, fz_s, fz_w;
  logic [W-1:0] rd_s, rd_w;
  logic [NCH-1:0] ov_s, ov_w;
  logic [1:0] st_s, st_w;

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(W), .SEL_W(SW), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clr(clr),
    .stall(stall), .evt(evt), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rv_s), .rd_data(rd_s), .ovf(ov_s), .frozen(fz_s),
    .state_o(st_s)
  );

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(W), .SEL_W(SW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .clr(clr),
    .stall(stall), .evt(evt), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rv_w), .rd_data(rd_w), .ovf(ov_w), .frozen(fz_w),
    .state_o(st_w)
  );

  always #5 clk = ~clk;

  int n[NCH];
  int cyc;
  int st;
  int q_s[$];
  int q_w[$];
  int last_s, last_w;
  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  function automatic int view(input int c, input bit sat);
    if (sat) return (c > MAXV) ? MAXV : c;
    return c % (MAXV + 1);
  endfunction

  function automatic int expect_rd(input int sel, input bit sat);
    if (sel < NCH) return view(n[sel], sat);
    if (sel == NCH && CYC_EN) return view(cyc, sat);
    return 0;
  endfunction

  function automatic int expect_ovf();
    int v = 0;
    for (int i = 0; i < NCH; i++)
      if (n[i] > MAXV) v |= (1 << i);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) n[i] = 0;
    cyc = 0;
    st = 0;
  endtask

  task automatic step(input int s, input int h, input int c, input int stl,
                      input int e, input int rq, input int sel);
    int es, ew;
    start = s[0]; halt = h[0]; clr = c[0]; stall = stl[0];
    evt = NCH'(e); rd_req = rq[0]; rd_sel = SW'(sel);
    es = expect_rd(sel, 1'b1);
    ew = expect_rd(sel, 1'b0);
    @(posedge clk);
    if (rq != 0) begin
      q_s.push_back(es);
      q_w.push_back(ew);
    end
    if (c != 0) begin
      model_clear();
    end else begin
      if (st == 1) begin
        for (int i = 0; i < NCH; i++)
          if (e[i] && stl == 0) n[i]++;
        cyc++;
      end
      if (st == 1 && h != 0) st = 2;
      else if (st == 0 && s != 0) st = 1;
    end
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int sel);
    step(0, 0, 0, 0, 0, 1, sel);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    start = 0; halt = 0; clr = 0; stall = 0; evt = '0; rd_req = 0;
    model_clear();
    q_s.delete();
    q_w.delete();
    last_s = 0;
    last_w = 0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rd_valid_sat", int'(rv_s), int'(q_s.size() != 0));
      chk("rd_valid_wrap", int'(rv_w), int'(q_w.size() != 0));
      if (q_s.size() != 0) begin
        last_s = q_s.pop_front();
        last_w = q_w.pop_front();
        chk("rd_data_sat", int'(rd_s), last_s);
        chk("rd_data_wrap", int'(rd_w), last_w);
      end else begin
        chk("rd_hold_sat", int'(rd_s), last_s);
        chk("rd_hold_wrap", int'(rd_w), last_w);
      end
      chk("state_sat", int'(st_s), st);
      chk("state_wrap", int'(st_w), st);
      chk("frozen_sat", int'(fz_s), int'(st == 2));
      chk("frozen_wrap", int'(fz_w), int'(st == 2));
      chk("ovf_sat", int'(ov_s), expect_ovf());
      chk("ovf_wrap", int'(ov_w), expect_ovf());
    end
  end

  initial begin
    model_clear();
    last_s = 0;
    last_w = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // events in IDLE are ignored
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 'h3F, 0, 0);
    for (int i = 0; i < NCH; i++) rd(i);

    // basic count, halt on the 10th event cycle, then frozen
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(0, (i == 9) ? 1 : 0, 0, 0, (i % 2 == 0) ? 'h09 : 'h01, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 'h3F, 0, 0);
    rd(0); rd(3);

    // stall gating
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, (i % 3 == 1) ? 1 : 0, 'h02, 0, 0);
    rd(1);

    // overflow on channel 2, then clr with a same-cycle read
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 'h04, 0, 0);
    rd(2);
    step(0, 0, 1, 0, 'h04, 1, 2);
    rd(2);

    // read racing an increment, out-of-range select, cycle counter index
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 'h10, 0, 0);
    step(0, 0, 0, 0, 'h10, 1, 4);
    rd(4); rd(7); rd(6);

    // clr beats halt and start
    step(1, 1, 1, 0, 'h3F, 0, 0);
    rd(4);

    // cycle counter: 12 RUN cycles, 4 stalled, halt on the 12th
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      step(0, (i == 11) ? 1 : 0, 0, (i % 3 == 0) ? 1 : 0, 'h01, 0, 0);
    rd(6); rd(0);

    // asynchronous reset mid-run discards counts and pending read
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 'h3F, 0, 0);
    step(0, 0, 0, 0, 'h3F, 1, 5);
    async_reset();
    rd(5); rd(6);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(int'($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 24) == 0),
           int'($urandom_range(0, 49) == 0),
           int'($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 63)),
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)));
    end

    idle(3);
    chk("queue_drained", q_s.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Synthesizable event-statistics unit for the pipelined processor. It replaces bench-only instruction and cache hit/request tallies with a parametrised bank of counters:
- NUM_CH event channels, each CNT_W wide, with a selectable saturate or wrap policy on overflow.
- Run/freeze control driven by start, halt and clear.
- A registered one-cycle read port.

It sits beside the core and takes per-cycle event strobes such as instruction retire, I-cache request/hit and D-cache request/hit, plus the pipeline stall qualifier.

Parameters:
NUM_CH, 6, number of event channels
CNT_W, 32, counter width in bits
SEL_W, 3, read-select width; must satisfy 2^SEL_W >= NUM_CH+1
SATURATE, 1, 1 = counters stick at all-ones on overflow; 0 = counters wrap to 0

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse; IDLE -> RUN
halt  in  1  processor halt strobe; RUN -> FROZEN
clr  in  1  synchronous clear of all counters and flags; returns to IDLE
stall  in  1  when 1, all evt strobes in that cycle are ignored
evt  in  NUM_CH  per-channel event strobes, one increment per cycle maximum
rd_req  in  1  read request, sampled each cycle
rd_sel  in  SEL_W  channel to read
rd_valid  out  1  rd_data valid this cycle
rd_data  out  CNT_W  counter value returned by the read
ovf  out  NUM_CH  sticky per-channel overflow flags
frozen  out  1  1 while in FROZEN
state_o  out  2  IDLE=0, RUN=1, FROZEN=2

Behaviour:
- Reset (rst_n=0, asynchronous): all counters 0, ovf 0, rd_valid 0, rd_data 0, state IDLE, frozen 0. Reset asserted mid-operation discards all counts immediately.
- States:
  - IDLE: no counting. start -> RUN.
  - RUN: counting. halt -> FROZEN.
  - FROZEN: no counting, values held. Leave only via clr or reset.
  - start in RUN or FROZEN is ignored.
- Control priority when asserted in the same cycle: clr > halt > start.
- clr in any state: next cycle all counters 0, ovf 0, state IDLE. A read sampled in the clr cycle returns the pre-clear value.
- Counting, in RUN only: counter i increments by 1 when evt[i] & ~stall.
  - Events in the halt cycle are counted; FROZEN takes effect from the next cycle.
  - Events in the start cycle are not counted, because the state is still IDLE.
- Overflow: an increment while the counter is all-ones sets ovf[i] (sticky until clr/reset).
  - SATURATE=1: counter holds all-ones.
  - SATURATE=0: counter becomes 0.
  - Further overflows leave ovf[i] at 1.
- Read port:
  - rd_req sampled at edge N gives rd_valid=1 in cycle N+1.
  - rd_data is the counter value before any increment at edge N.
  - Reads are legal in every state. Back-to-back reads deliver one result per cycle.
  - rd_valid=0 when no request is pending; rd_data then holds its last value.
  - rd_sel >= NUM_CH returns 0 with rd_valid=1, except the cycle-counter index when that feature is compiled in.
- Counting has no combinational path from evt to rd_data; all outputs are registered.

Optional Feature:
PERF_CYCLE_CNT_EN
- Defined: adds a CNT_W cycle counter, readable at rd_sel == NUM_CH.
  - Increments every cycle spent in RUN, including stall cycles and the halt cycle.
  - Obeys SATURATE and is cleared by clr/reset.
  - Has no ovf bit.
- Undefined: no cycle counter exists; rd_sel == NUM_CH returns 0.

Test Plan:
- Reset and idle: reset, pulse evt=6'h3F for 5 cycles in IDLE, read channels 0..5 -> all rd_data 0, ovf 0, state_o 0.
- Basic count: start, then 10 cycles with evt[0]=1, evt[3] on alternate cycles, halt on the 10th cycle -> ch0=10, ch3=5, frozen=1. Further events leave the values unchanged.
- Stall gating: in RUN drive evt[1]=1 for 8 cycles with stall=1 on 3 of them -> ch1=5.
- Overflow (CNT_W=4):
  - SATURATE=1, 17 events on ch2 -> ch2=15, ovf[2]=1.
  - SATURATE=0, same stimulus -> ch2=1, ovf[2]=1.
  - Then clr -> ch2=0, ovf=0, state IDLE.
- Read timing and priority:
  - rd_req in the same cycle as an evt[4] increment -> returns the old value next cycle.
  - rd_sel=7 with NUM_CH=6 -> rd_data 0, rd_valid 1.
  - clr+halt+start together in RUN -> IDLE with counters 0.
- Cycle counter (PERF_CYCLE_CNT_EN): start, 12 RUN cycles with 4 stalled, halt on the 12th -> rd_sel=6 returns 12. Rebuilt without the macro -> returns 0.
